not_gate_arbiter: RTL and testbench

NOT_GATE_ARBITER -- requirements
Module: not_gate_arbiter

---
 rtl/not_gate_arbiter.sv | 120 ++++++++++++
 tb/tb_not_gate_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/not_gate_arbiter.sv
// Round-robin arbiter sharing one registered inverter among NUM_REQ requesters.
// Optional feature: define NOT_ARB_LOCK_EN to add a lock input that pins priority on the granted requester.
module not_gate_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef NOT_ARB_LOCK_EN
  input  logic                       lock,
`endif
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   in_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  input  logic                       out_ready
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [ID_W-1:0]   out_id_reg;
  logic [WIDTH-1:0]  out_data_reg;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              stage_free;
  logic              grant_any;
  logic [WIDTH-1:0]  operand [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_operand
      assign operand[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search upward from ptr, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = ID_W'((int'(ptr_reg) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // gnt is held low during reset even though the state reads EMPTY.
  assign stage_free = (state_reg == EMPTY) || out_ready;
  assign grant_any  = found && stage_free && !rst;
  assign gnt        = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) begin
      if (grant_idx == ID_W'(NUM_REQ - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_idx + ID_W'(1);
      end
`ifdef NOT_ARB_LOCK_EN
      if (lock) begin
        ptr_next = grant_idx;
      end
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (grant_any) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_next = grant_any ? FULL : EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg      <= '0;
      out_id_reg   <= '0;
      out_data_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (grant_any) begin
        out_id_reg   <= grant_idx;
        out_data_reg <= ~operand[grant_idx];
      end
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = out_data_reg;
  assign out_id    = out_id_reg;

endmodule

// File: tb/tb_not_gate_arbiter.sv
// Scoreboard bench for not_gate_arbiter: stimulus pushes expected results, a monitor pops on each handshake.
// Lock-mode vectors run only when NOT_ARB_LOCK_EN is defined.
module tb_not_gate_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lock = 1'b0;
  logic [3:0]  req = 4'b1111;
  logic [31:0] in_data = 32'h4433_2211;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  not_gate_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef NOT_ARB_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive off-edge, check combinational grant, queue the expected result.
  task automatic step(input logic [3:0] r, input logic [31:0] d, input logic rdy,
                      input logic [3:0] eg, input logic [1:0] eid, input logic [7:0] edata);
    @(posedge clk);
    #1;
    req = r; in_data = d; out_ready = rdy;
    #2;
    chk("gnt", 32'(gnt), 32'(eg));
    if (eg != 4'b0000) exp_q.push_back({eid, edata});
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got id=%0d data=%0h expected none", out_id, out_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        $display("result id=%0d data=%02h (expect id=%0d data=%02h)", out_id, out_data, e[9:8], e[7:0]);
        chk("out_id", 32'(out_id), 32'(e[9:8]));
        chk("out_data", 32'(out_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; req = 4'b0000;

    // All requesting: order 0,1,2,3,0 at one result per clock
    step(4'b1111, 32'h4433_2211, 1'b1, 4'b0001, 2'd0, 8'hEE);
    step(4'b1111, 32'h4433_2211, 1'b1, 4'b0010, 2'd1, 8'hDD);
    step(4'b1111, 32'h4433_2211, 1'b1, 4'b0100, 2'd2, 8'hCC);
    step(4'b1111, 32'h4433_2211, 1'b1, 4'b1000, 2'd3, 8'hBB);
    step(4'b1111, 32'h4433_2211, 1'b1, 4'b0001, 2'd0, 8'hEE);
    step(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 2'd0, 8'h00);

    // Single request, then pointer wrap from 3
    step(4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 2'd2, 8'h5A);
    step(4'b1001, 32'h3C00_000F, 1'b1, 4'b1000, 2'd3, 8'hC3);
    step(4'b1001, 32'h3C00_000F, 1'b1, 4'b0001, 2'd0, 8'hF0);

    // Backpressure: F0 held, no grants, then release grants requester 1
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, 32'h0000_7700, 1'b0, 4'b0000, 2'd0, 8'h00);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'hF0);
      chk("stall_id", 32'(out_id), 32'd0);
    end
    step(4'b0011, 32'h0000_7700, 1'b1, 4'b0010, 2'd1, 8'h88);
    step(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 2'd0, 8'h00);

    // Reset while FULL discards the result before the next edge
    step(4'b0001, 32'h0000_00A0, 1'b1, 4'b0001, 2'd0, 8'h5F);
    step(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 2'd0, 8'h00);
    chk("full_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1; req = 4'b1111;
    #2;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0; req = 4'b0000;

    // Priority restarts at 0 after reset
    step(4'b0110, 32'h0000_2200, 1'b1, 4'b0010, 2'd1, 8'hDD);

`ifdef NOT_ARB_LOCK_EN
    lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, 32'h0000_0055, 1'b1, 4'b0001, 2'd0, 8'hAA);
    end
    lock = 1'b0;
    step(4'b0011, 32'h0000_0055, 1'b1, 4'b0001, 2'd0, 8'hAA);
    step(4'b0011, 32'h0000_6655, 1'b1, 4'b0010, 2'd1, 8'h99);
`endif

    step(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 2'd0, 8'h00);
    step(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 2'd0, 8'h00);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
